// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing constants, coordinate type and range helper
//
// Default 640x480@60 timing, the totals and sync spans derived from it, and the
// coordinate width shared by the raster generator and the crosshair overlay.
// The DEF_ prefix keeps these names distinct from the per-instance parameters of
// vga_timing, so a wildcard import never shadows them.
package vga_pkg;

  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_CLK_DIV  = 2;

  localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + DEF_H_SYNC - 1;
  localparam int V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + DEF_V_SYNC - 1;

  // Inclusive range test on a coordinate.
  function automatic logic in_span(input coord_t v, input int lo, input int hi);
    return (int'(v) >= lo) && (int'(v) <= hi);
  endfunction

endpackage

// File: rtl/pix_tick_gen.sv
// rtl/pix_tick_gen.sv - clock divider producing the one-clk pixel strobe
//
// Ports:
//   clk      in   system clock
//   rst      in   synchronous reset, active-high
//   pix_tick out  high for one clk every CLK_DIV clks (constantly high for CLK_DIV=1)
module pix_tick_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  output logic pix_tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_q;
  logic [DIV_W-1:0] div_cnt_d;

  always_comb begin
    div_cnt_d = div_cnt_q + 1'b1;
    if (div_cnt_q == DIV_LAST) begin
      div_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

  // With CLK_DIV=1 the counter is pinned at 0, which equals DIV_LAST.
  assign pix_tick = (div_cnt_q == DIV_LAST);

endmodule

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - VGA raster counters with registered sync/active/frame decode
//
// Ports:
//   clk         in   system clock
//   rst         in   synchronous reset, active-high
//   pix_tick    out  one-clk pixel strobe
//   column      out  horizontal counter, 0..H_TOTAL-1 (raw, includes blanking)
//   row         out  vertical counter, 0..V_TOTAL-1 (raw, includes blanking)
//   hsync       out  horizontal sync, active low
//   vsync       out  vertical sync, active low
//   video_on    out  high inside the visible area
//   frame_start out  one-clk pulse when the raster has just wrapped to (0,0)
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int CLK_DIV  = DEF_CLK_DIV
) (
  input  logic               clk,
  input  logic               rst,
  output logic               pix_tick,
  output logic [COORD_W-1:0] column,
  output logic [COORD_W-1:0] row,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic               frame_start
);

  localparam int HT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_LO = H_ACTIVE + H_FP;
  localparam int HS_HI = HS_LO + H_SYNC - 1;
  localparam int VS_LO = V_ACTIVE + V_FP;
  localparam int VS_HI = VS_LO + V_SYNC - 1;
  localparam coord_t COL_LAST = coord_t'(HT - 1);
  localparam coord_t ROW_LAST = coord_t'(VT - 1);

  coord_t column_q, column_d;
  coord_t row_q, row_d;
  logic   hsync_q, hsync_d;
  logic   vsync_q, vsync_d;
  logic   video_on_q, video_on_d;
  logic   frame_start_q, frame_start_d;

  pix_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_tick_gen (
    .clk      (clk),
    .rst      (rst),
    .pix_tick (pix_tick)
  );

  always_comb begin
    column_d = column_q;
    row_d    = row_q;
    if (pix_tick) begin
      if (column_q == COL_LAST) begin
        column_d = '0;
        row_d    = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        column_d = column_q + 1'b1;
      end
    end

    // Decoding the next-state counters lets the registered flags line up with
    // the row/column they describe instead of trailing them by one clk.
    hsync_d       = !in_span(column_d, HS_LO, HS_HI);
    vsync_d       = !in_span(row_d, VS_LO, VS_HI);
    video_on_d    = (int'(column_d) < H_ACTIVE) && (int'(row_d) < V_ACTIVE);
    frame_start_d = pix_tick && (column_q == COL_LAST) && (row_q == ROW_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      column_q      <= '0;
      row_q         <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      column_q      <= column_d;
      row_q         <= row_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign column      = column_q;
  assign row         = row_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign frame_start = frame_start_q;

endmodule

// File: doc/vga_timing.md
Name: vga_timing

Overview:
- Generates the 640x480@60 Hz VGA raster that feeds the crosshair overlay and the other pixel generators.
- Outputs the current pixel coordinates (row, column), active-low sync pulses and a video-active flag.
- Outputs a once-per-frame strobe. The crosshair position counter uses this strobe as its count enable, so the crosshair moves at frame rate.
- Sits directly upstream of the overlay logic and downstream of the board clock.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 2, clk cycles per pixel; 2 gives 25 MHz from the 50 MHz board clock; must be >= 1

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- pix_tick  out  1  high for one clk each pixel period
- column  out  10  horizontal counter, 0..H_TOTAL-1
- row  out  10  vertical counter, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- video_on  out  1  high when column < H_ACTIVE and row < V_ACTIVE
- frame_start  out  1  one-clk pulse when the raster wraps to (0,0)

Behaviour:
- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP = 525
  - Both totals must fit in 10 bits.
- Clock and reset:
  - Single clock domain.
  - rst is sampled on the rising clk edge and takes priority over all other logic.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 every clk and wraps to 0.
  - pix_tick = (div_cnt == CLK_DIV-1).
  - With CLK_DIV=1, pix_tick is constantly 1 when not in reset.
- Counters: advance only on a clk edge where pix_tick=1.
  - column increments by 1. At H_TOTAL-1 it wraps to 0.
  - On a column wrap, row increments by 1. At V_TOTAL-1 it wraps to 0.
  - row holds at all other times.
- Output decode: hsync, vsync, video_on and frame_start are registers, updated on the same edge as the counters, from the next-state counter values. They are therefore always consistent with the row/column values presented in the same cycle, with no extra pipeline delay.
  - hsync = 0 iff H_ACTIVE+H_FP <= column <= H_ACTIVE+H_FP+H_SYNC-1 (656..751).
  - vsync = 0 iff V_ACTIVE+V_FP <= row <= V_ACTIVE+V_FP+V_SYNC-1 (490..491). vsync is decoded on row only and changes together with the row increment.
  - video_on = (column < H_ACTIVE) && (row < V_ACTIVE).
  - frame_start = 1 for exactly one clk: the cycle in which the counters have just wrapped from (H_TOTAL-1, V_TOTAL-1) to (0,0). It stays 0 the rest of the frame. It is not asserted by reset itself.
- Blanking: row and column report raw counter values, up to 799/524. Downstream blocks gate with video_on.
- Reset values: div_cnt 0, pix_tick 0 (when CLK_DIV>1), column 0, row 0, hsync 1, vsync 1, video_on 1, frame_start 0.
- Reset mid-frame: on the next edge, all state returns to the reset values. The first pixel after rst deasserts is (0,0), shown for CLK_DIV clks.
- No other inputs exist, so there are no simultaneous-event cases beyond column wrap coinciding with row wrap. That case is handled as stated: both wrap on the same edge and frame_start fires.

Decomposition:
- Package vga_pkg:
  - Default timing constants (H_ACTIVE..V_BP).
  - Derived H_TOTAL and V_TOTAL.
  - Sync-start/end localparams.
  - Coordinate width constant (10), shared with the crosshair overlay.
- Sub-module pix_tick_gen (parameter CLK_DIV; ports clk, rst, pix_tick) holds the divider. The counter and decode logic stay in vga_timing.

Test Plan:
- Reset then release with CLK_DIV=2 -> pix_tick high every 2nd clk; column steps 0,1,2… once per tick; hsync=vsync=1, video_on=1, frame_start=0 during and right after reset.
- One full line -> video_on falls when column goes 639->640; hsync low for exactly 96 ticks (columns 656..751); column wraps 799->0 and row increments 0->1 on the same edge.
- Full frame -> vsync low exactly for rows 490..491 (1600 ticks); video_on low for all rows >= 480; row wraps 524->0.
- Frame strobe -> frame_start pulses exactly once per 420000 ticks (840000 clks at CLK_DIV=2), in the cycle where row=0 and column=0; no pulse on the first frame after reset.
- Reset mid-frame at row=300, column=400 -> next edge gives row=0, column=0, div_cnt=0, all outputs at reset values; counting resumes normally.
- CLK_DIV=1 build -> pix_tick constantly 1 outside reset; line period is 800 clks; sync widths unchanged in ticks.
